// File: rtl/connector_pkg.sv
// ----------------------------------------------------------------------------
// connector_pkg
// Shared types and default sizes for the connector write path.
//   CONN_N_REQ      default number of write requesters
//   CONN_DATA_W     default write data width
//   conn_src_t      channel index type for the default requester count
//   conn_wr_state_t output slot state (empty / holding a word)
// ----------------------------------------------------------------------------
package connector_pkg;

    localparam int CONN_N_REQ  = 3;
    localparam int CONN_DATA_W = 8;

    typedef logic [$clog2(CONN_N_REQ)-1:0] conn_src_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_VALID = 1'b1
    } conn_wr_state_t;

endpackage : connector_pkg

// File: rtl/connector_chan_fifo.sv
// ----------------------------------------------------------------------------
// connector_chan_fifo
// Small per-channel FIFO for one write requester.
//   clk      in   clock, posedge
//   reset_n  in   asynchronous active-low reset (pointers only)
//   i_push   in   write strobe
//   i_wdata  in   write data
//   i_pop    in   remove head word
//   o_full   out  FIFO holds FIFO_DEPTH words
//   o_empty  out  FIFO holds no word
//   o_rdata  out  head word, combinational
// A push on a full FIFO is taken only when a pop happens on the same edge,
// since that pop frees the slot the push writes into.
// ----------------------------------------------------------------------------
module connector_chan_fifo
    import connector_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra MSB on each pointer separates full from empty when LSBs match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule : connector_chan_fifo

// File: rtl/connector_wr_arbiter.sv
// ----------------------------------------------------------------------------
// connector_wr_arbiter
// Round-robin merge of N_REQ write channels onto one valid/ready byte port.
//   clk       in   clock, posedge
//   reset_n   in   asynchronous active-low reset
//   freeze    in   block loading new words into the output slot
//   wen_i     in   per-channel write strobe
//   data_i    in   channel k data at [k*DATA_W +: DATA_W]
//   wr_ready  in   sink accepts wr_data this cycle
//   wr_en     out  output word valid
//   wr_data   out  output word
//   wr_src    out  channel that supplied wr_data
//   pend      out  per-channel FIFO non-empty
//   ovf       out  sticky per-channel dropped-push flag
//   ovf_clr   in   clear all ovf bits
// ----------------------------------------------------------------------------
module connector_wr_arbiter
    import connector_pkg::*;
#(
    parameter int N_REQ      = CONN_N_REQ,
    parameter int DATA_W     = CONN_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      freeze,
    input  logic [N_REQ-1:0]          wen_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    input  logic                      wr_ready,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(N_REQ)-1:0]  wr_src,
    output logic [N_REQ-1:0]          pend,
    output logic [N_REQ-1:0]          ovf,
    input  logic                      ovf_clr
);

    localparam int SRC_W = $clog2(N_REQ);

    conn_wr_state_t     r_state;
    logic [DATA_W-1:0]  r_wr_data;
    logic [SRC_W-1:0]   r_wr_src;
    logic [SRC_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_ovf;

    logic [N_REQ-1:0]   w_full;
    logic [N_REQ-1:0]   w_empty;
    logic [N_REQ-1:0]   w_nonempty;
    logic [N_REQ-1:0]   w_pop;
    logic [N_REQ-1:0]   w_drop;
    logic [N_REQ-1:0]   w_hi_mask;
    logic [N_REQ-1:0]   w_hi_req;
    logic [DATA_W-1:0]  w_rdata [N_REQ];
    logic [SRC_W-1:0]   w_grant;
    logic               w_slot_free;
    logic               w_load;

    function automatic logic [SRC_W-1:0] f_lowest(input logic [N_REQ-1:0] v);
        f_lowest = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = SRC_W'(i);
        end
    endfunction

    assign w_nonempty = ~w_empty;

    // Round robin: prefer requesters above the last grant, else wrap to the
    // lowest requester overall.
    assign w_hi_req = w_nonempty & w_hi_mask;
    assign w_grant  = (|w_hi_req) ? f_lowest(w_hi_req) : f_lowest(w_nonempty);

    // The slot can take a new word when empty or when the current word is
    // being accepted; a held word is never replaced, frozen or not.
    assign w_slot_free = (r_state == WR_IDLE) || wr_ready;
    assign w_load      = w_slot_free && !freeze && (|w_nonempty);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_chan
            connector_chan_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .i_push  (wen_i[gi]),
                .i_wdata (data_i[gi*DATA_W +: DATA_W]),
                .i_pop   (w_pop[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi]),
                .o_rdata (w_rdata[gi])
            );

            assign w_hi_mask[gi] = (SRC_W'(gi) > r_ptr);
            assign w_pop[gi]     = w_load && (w_grant == SRC_W'(gi));
            // A same-edge pop frees the slot, so only an un-popped full FIFO drops.
            assign w_drop[gi]    = wen_i[gi] && w_full[gi] && !w_pop[gi];

            // New overflow beats a simultaneous clear.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_ovf[gi] <= 1'b0;
                end else if (w_drop[gi]) begin
                    r_ovf[gi] <= 1'b1;
                end else if (ovf_clr) begin
                    r_ovf[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= WR_IDLE;
            r_wr_data <= '0;
            r_wr_src  <= '0;
            r_ptr     <= SRC_W'(N_REQ - 1);
        end else if (w_load) begin
            r_state   <= WR_VALID;
            r_wr_data <= w_rdata[w_grant];
            r_wr_src  <= w_grant;
            r_ptr     <= w_grant;
        end else if (wr_ready) begin
            r_state   <= WR_IDLE;
        end
    end

    assign wr_en   = (r_state == WR_VALID);
    assign wr_data = r_wr_data;
    assign wr_src  = r_wr_src;
    assign pend    = w_nonempty;
    assign ovf     = r_ovf;

endmodule : connector_wr_arbiter
